pic8259: RTL and testbench

Synchronous single-device 8259A-compatible programmable interrupt controller for the PC system board. It sits directly downstream of `intel8253`: `ir[0]` is driven by timer channel 0 (`out[0]`), and the keyboard, floppy and other sources drive `ir[7:1]`. It collects edge-triggered requests, resolves fixed priority against an 8-bit mask, raises `intr` to the CPU, and answers the two-pulse 8086 INTA handshake with an 8-bit vector. Scope is PC mode only: single device, edge-triggered, fixed priority, normal EOI or AEOI.

---
 rtl/pic8259_pkg.sv | 16 +
 rtl/pic8259_prio.sv | 18 +
 rtl/pic8259.sv | 184 ++++++++++++++++++
 tb/tb_pic8259.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pic8259_pkg.sv
// Shared types for the 8259A-compatible PIC: init/INTA state enums, OCW2 EOI codes
// and a lowest-set-bit helper used by the priority resolver.
package pic8259_pkg;
  typedef enum logic [2:0] {UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} init_st_e;
  typedef enum logic [1:0] {IDLE, ACK1, ACK2} inta_st_e;

  localparam logic [2:0] EOI_NS = 3'b001;
  localparam logic [2:0] EOI_SP = 3'b011;

  // Index of the lowest set bit (bit 0 = highest priority); 7 when empty.
  function automatic logic [2:0] lsb_idx(input logic [7:0] v);
    lsb_idx = 3'd7;
    for (int i = 7; i >= 0; i--)
      if (v[i]) lsb_idx = 3'(i);
  endfunction
endpackage

// File: rtl/pic8259_prio.sv
// Combinational fixed-priority resolver: winning unmasked request and top in-service level.
module pic8259_prio
  import pic8259_pkg::*;
(
  input  logic [7:0] irr_i,
  input  logic [7:0] imr_i,
  input  logic [7:0] isr_i,
  output logic       req_o,
  output logic [2:0] win_o,
  output logic [2:0] isr_top_o
);
  logic [7:0] pend;

  assign pend      = irr_i & ~imr_i;
  assign req_o     = |pend;
  assign win_o     = lsb_idx(pend);
  assign isr_top_o = lsb_idx(isr_i);
endmodule

// File: rtl/pic8259.sv
// Single-device 8259A-style PIC: edge-triggered IRR, fixed priority, normal EOI / AEOI,
// two-pulse 8086 INTA handshake returning {vec_base, level}.
module pic8259
  import pic8259_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] ir,
  input  logic       inta_n,
  output logic       intr
);
  logic [SYNC_STAGES-1:0][7:0] ir_sync_q;
  logic [7:0] ir_prev_q;
  logic       wr_s_q, wr_p_q, cs_s_q, cs_p_q, a0_s_q, a0_p_q, inta_s_q, inta_p_q;
  logic [7:0] d_s_q, d_p_q;

  init_st_e   init_q, init_d;
  inta_st_e   inta_q, inta_d;
  logic [7:0] imr_q, imr_d, isr_q, isr_d, irr_q, irr_d, ack_clr;
  logic [4:0] base_q, base_d;
  logic [2:0] n_q, n_d;
  logic       aeoi_q, aeoi_d, sngl_q, sngl_d, ic4_q, ic4_d, rsel_q, rsel_d;
  logic       spur_q, spur_d, intr_q, intr_d;

  logic [7:0] ir_s, ir_rise;
  logic       wcommit, icw1, inta_fall, inta_rise, req;
  logic [2:0] win, isr_top;
  logic       vec_drv, rd_drv;

  pic8259_prio u_prio (
    .irr_i(irr_q), .imr_i(imr_q), .isr_i(isr_q),
    .req_o(req), .win_o(win), .isr_top_o(isr_top)
  );

  assign ir_s      = ir_sync_q[SYNC_STAGES-1];
  assign ir_rise   = ir_s & ~ir_prev_q;
  // A write commits once wr_n is seen high after a low sample; the bus fields come from that low sample.
  assign wcommit   = wr_s_q & ~wr_p_q & ~cs_p_q;
  assign icw1      = wcommit & ~a0_p_q & d_p_q[4];
  assign inta_fall = inta_p_q & ~inta_s_q;
  assign inta_rise = ~inta_p_q & inta_s_q;

  always_comb begin
    init_d  = init_q;
    inta_d  = inta_q;
    imr_d   = imr_q;
    isr_d   = isr_q;
    base_d  = base_q;
    aeoi_d  = aeoi_q;
    sngl_d  = sngl_q;
    ic4_d   = ic4_q;
    rsel_d  = rsel_q;
    n_d     = n_q;
    spur_d  = spur_q;
    ack_clr = '0;

    if (icw1) begin
      sngl_d = d_p_q[1];
      ic4_d  = d_p_q[0];
      imr_d  = 8'h00;
      isr_d  = 8'h00;
      rsel_d = 1'b0;
      inta_d = IDLE;
      init_d = WAIT_ICW2;
    end else if (wcommit) begin
      unique case (init_q)
        WAIT_ICW2: if (a0_p_q) begin
          base_d = d_p_q[7:3];
          init_d = !sngl_q ? WAIT_ICW3 : (ic4_q ? WAIT_ICW4 : READY);
        end
        WAIT_ICW3: if (a0_p_q) init_d = ic4_q ? WAIT_ICW4 : READY;
        WAIT_ICW4: if (a0_p_q) begin
          aeoi_d = d_p_q[1];
          init_d = READY;
        end
        READY: begin
          if (a0_p_q) imr_d = d_p_q;
          else if (d_p_q[4:3] == 2'b00) begin
            if (d_p_q[7:5] == EOI_NS)      isr_d[isr_top]    = 1'b0;
            else if (d_p_q[7:5] == EOI_SP) isr_d[d_p_q[2:0]] = 1'b0;
          end else if (d_p_q[4:3] == 2'b01 && d_p_q[1]) rsel_d = d_p_q[0];
        end
        default: ;
      endcase
    end

    // INTA runs after the write decode so an ack set survives a same-cycle EOI clear.
    if (!icw1) begin
      unique case (inta_q)
        IDLE: if (inta_fall && init_q == READY) begin
          inta_d = ACK1;
          n_d    = req ? win : 3'd7;
          spur_d = !req;
          if (req) begin
            isr_d[win]   = 1'b1;
            ack_clr[win] = 1'b1;
          end
        end
        ACK1: if (inta_rise) inta_d = ACK2;
        ACK2: if (inta_rise) begin
          inta_d = IDLE;
          if (aeoi_q && !spur_q) isr_d[n_q] = 1'b0;
        end
        default: inta_d = IDLE;
      endcase
    end

    irr_d  = icw1 ? 8'h00 : ((irr_q | ir_rise) & ir_s & ~ack_clr);
    intr_d = (init_q == READY) && (inta_q == IDLE) && !inta_fall && req &&
             (~|isr_q || (win < isr_top));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_sync_q <= '0;
      ir_prev_q <= '0;
      wr_s_q    <= 1'b1;
      wr_p_q    <= 1'b1;
      cs_s_q    <= 1'b1;
      cs_p_q    <= 1'b1;
      a0_s_q    <= 1'b0;
      a0_p_q    <= 1'b0;
      d_s_q     <= '0;
      d_p_q     <= '0;
      inta_s_q  <= 1'b1;
      inta_p_q  <= 1'b1;
      init_q    <= UNINIT;
      inta_q    <= IDLE;
      imr_q     <= 8'hFF;
      isr_q     <= '0;
      irr_q     <= '0;
      base_q    <= '0;
      aeoi_q    <= 1'b0;
      sngl_q    <= 1'b0;
      ic4_q     <= 1'b0;
      rsel_q    <= 1'b0;
      n_q       <= '0;
      spur_q    <= 1'b0;
      intr_q    <= 1'b0;
    end else begin
      ir_sync_q <= {ir_sync_q[SYNC_STAGES-2:0], ir};
      ir_prev_q <= ir_s;
      wr_s_q    <= wr_n;
      wr_p_q    <= wr_s_q;
      cs_s_q    <= cs_n;
      cs_p_q    <= cs_s_q;
      a0_s_q    <= a0;
      a0_p_q    <= a0_s_q;
      d_s_q     <= d_in;
      d_p_q     <= d_s_q;
      inta_s_q  <= inta_n;
      inta_p_q  <= inta_s_q;
      init_q    <= init_d;
      inta_q    <= inta_d;
      imr_q     <= imr_d;
      isr_q     <= isr_d;
      irr_q     <= irr_d;
      base_q    <= base_d;
      aeoi_q    <= aeoi_d;
      sngl_q    <= sngl_d;
      ic4_q     <= ic4_d;
      rsel_q    <= rsel_d;
      n_q       <= n_d;
      spur_q    <= spur_d;
      intr_q    <= intr_d;
    end
  end

  assign intr    = intr_q;
  assign vec_drv = (inta_q == ACK2) && !inta_n;
  assign rd_drv  = !cs_n && !rd_n && wr_n;
  assign d_oe    = vec_drv | rd_drv;
  assign d_out   = vec_drv ? {base_q, n_q} :
                   rd_drv  ? (a0 ? imr_q : (rsel_q ? isr_q : irr_q)) : 8'h00;
endmodule

// File: tb/tb_pic8259.sv
// Directed + randomized bench for pic8259 against a transaction-level model of the
// IRR/IMR/ISR rules (requests held high until acknowledged).
module tb_pic8259;
  logic       clk = 1'b0;
  logic       rst_n, cs_n, rd_n, wr_n, a0, inta_n, d_oe, intr;
  logic [7:0] d_in, d_out, ir;

  int n_chk = 0, n_err = 0;

  logic [7:0] m_imr, m_isr, m_irr, ir_lvl;
  logic [4:0] m_base;
  logic       m_aeoi, m_ready;

  logic [7:0] v, r_imr, r_ir;
  logic       oe;

  pic8259 #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
    .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .ir(ir), .inta_n(inta_n), .intr(intr)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input logic [7:0] x);
    for (int i = 0; i < 8; i++) if (x[i]) return i;
    return 8;
  endfunction

  function automatic logic exp_intr();
    return m_ready && (lowest(m_irr & ~m_imr) < lowest(m_isr));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    @(negedge clk); cs_n = 1'b0; a0 = a; d_in = d; wr_n = 1'b0;
    @(negedge clk); wr_n = 1'b1; cs_n = 1'b1;
    idle(3);
  endtask

  task automatic rd(input logic a, output logic [7:0] d, output logic o);
    @(negedge clk); cs_n = 1'b0; rd_n = 1'b0; a0 = a;
    #1; d = d_out; o = d_oe;
    rd_n = 1'b1; cs_n = 1'b1;
  endtask

  task automatic chk_isr(input string tag);
    logic [7:0] x; logic o;
    wr(1'b0, 8'h0B);
    rd(1'b0, x, o);
    chk(tag, x, m_isr);
  endtask

  task automatic chk_irr(input string tag);
    logic [7:0] x; logic o;
    wr(1'b0, 8'h0A);
    rd(1'b0, x, o);
    chk(tag, x, m_irr);
  endtask

  task automatic set_ir(input logic [7:0] lv);
    @(negedge clk); ir = lv;
    m_irr = (m_irr | (lv & ~ir_lvl)) & lv;
    ir_lvl = lv;
    idle(5);
  endtask

  task automatic eoi_ns();
    wr(1'b0, 8'h20);
    if (m_isr != 8'h00) m_isr[lowest(m_isr)] = 1'b0;
  endtask

  task automatic inta(output logic [7:0] vec, output logic o, output logic im);
    @(negedge clk); inta_n = 1'b0;
    idle(3); im = intr; inta_n = 1'b1;
    idle(3); inta_n = 1'b0;
    #1; vec = d_out; o = d_oe;
    idle(2); inta_n = 1'b1;
    idle(4);
  endtask

  task automatic do_ack(input string tag);
    logic [7:0] vv, ev; logic o, im; int w;
    w  = lowest(m_irr & ~m_imr);
    ev = (w < 8) ? 8'(m_base * 8 + w) : 8'(m_base * 8 + 7);
    inta(vv, o, im);
    chk({tag, "_vec"}, vv, ev);
    chk({tag, "_vecoe"}, 8'(o), 8'd1);
    chk({tag, "_ackintr"}, 8'(im), 8'd0);
    if (w < 8) begin
      m_irr[w] = 1'b0;
      if (!m_aeoi) m_isr[w] = 1'b1;
    end
    chk({tag, "_intr"}, 8'(intr), 8'(exp_intr()));
  endtask

  task automatic do_init(input logic [7:0] icw4);
    wr(1'b0, 8'h13); m_imr = 8'h00; m_isr = 8'h00; m_irr = 8'h00; m_ready = 1'b0;
    wr(1'b1, 8'h08); m_base = 5'd1;
    wr(1'b1, icw4);  m_aeoi = icw4[1]; m_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a0 = 1'b0;
    d_in = 8'h00; ir = 8'h00; inta_n = 1'b1;
    m_imr = 8'hFF; m_isr = 8'h00; m_irr = 8'h00; ir_lvl = 8'h00;
    m_base = 5'd0; m_aeoi = 1'b0; m_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_intr", 8'(intr), 8'd0);
    chk("rst_doe", 8'(d_oe), 8'd0);
    chk("rst_dout", d_out, 8'h00);
    idle(2); rst_n = 1'b1; idle(2);
    rd(1'b1, v, oe); chk("rst_imr", v, m_imr); chk("rst_rdoe", 8'(oe), 8'd1);
    rd(1'b0, v, oe); chk("rst_irr", v, m_irr);

    // Timer interrupt with exact ir->intr latency, normal EOI
    do_init(8'h09);
    wr(1'b1, 8'hFE); m_imr = 8'hFE;
    @(negedge clk); ir = 8'h01; m_irr = 8'h01; ir_lvl = 8'h01;
    idle(3); chk("tmr_intr_k2", 8'(intr), 8'd0);
    idle(1); chk("tmr_intr_k3", 8'(intr), 8'(exp_intr()));
    do_ack("tmr");
    chk_isr("tmr_isr");
    eoi_ns();
    chk_isr("tmr_isr_eoi");
    set_ir(8'h00);

    // Nesting
    wr(1'b1, 8'h00); m_imr = 8'h00;
    set_ir(8'h08); chk("nest_intr3", 8'(intr), 8'(exp_intr()));
    do_ack("nest3");
    set_ir(8'h0A); chk("nest_intr1", 8'(intr), 8'(exp_intr()));
    do_ack("nest1");
    chk_isr("nest_isr");
    eoi_ns();
    set_ir(8'h2A); chk("nest_blk5", 8'(intr), 8'(exp_intr()));
    set_ir(8'h00); eoi_ns();
    chk_isr("nest_isr_clr");

    // Masked request
    wr(1'b1, 8'hFF); m_imr = 8'hFF;
    set_ir(8'h04);
    chk_irr("mask_irr");
    chk("mask_intr", 8'(intr), 8'(exp_intr()));
    wr(1'b1, 8'hFB); m_imr = 8'hFB;
    chk("unmask_intr", 8'(intr), 8'(exp_intr()));
    do_ack("mask");
    eoi_ns(); set_ir(8'h00);

    // AEOI and spurious
    do_init(8'h0B);
    set_ir(8'h10); chk("aeoi_intr", 8'(intr), 8'(exp_intr()));
    do_ack("aeoi");
    chk_isr("aeoi_isr");
    set_ir(8'h00);
    do_ack("spur_aeoi");

    // Specific EOI, ISR read, spurious with ISR held
    do_init(8'h09);
    set_ir(8'h04); do_ack("sp2");
    set_ir(8'h06); do_ack("sp1");
    chk_isr("sp_isr06");
    wr(1'b0, 8'h62); m_isr[2] = 1'b0;
    chk_isr("sp_isr02");
    do_ack("spur_norm");
    chk_isr("spur_isr");
    eoi_ns(); set_ir(8'h00);

    // Randomized masks, request patterns and EOI choices
    for (int it = 0; it < 12; it++) begin
      set_ir(8'h00);
      r_imr = 8'($urandom);
      wr(1'b1, r_imr); m_imr = r_imr;
      rd(1'b1, v, oe); chk("rnd_imr", v, m_imr);
      r_ir = 8'($urandom);
      set_ir(r_ir);
      chk("rnd_intr", 8'(intr), 8'(exp_intr()));
      chk_irr("rnd_irr");
      do_ack("rnd");
      if ($urandom_range(1, 0) == 1) eoi_ns();
      chk_isr("rnd_isr");
    end
    set_ir(8'h00);
    wr(1'b1, 8'h00); m_imr = 8'h00;
    for (int i = 0; i < 8; i++) eoi_ns();
    chk_isr("rnd_isr_clr");

    // Reset in the middle of an INTA sequence
    set_ir(8'h01);
    chk("pre_rst_intr", 8'(intr), 8'(exp_intr()));
    @(negedge clk); inta_n = 1'b0;
    idle(2); rst_n = 1'b0;
    #1;
    chk("mid_rst_intr", 8'(intr), 8'd0);
    chk("mid_rst_doe", 8'(d_oe), 8'd0);
    idle(1); rst_n = 1'b1; inta_n = 1'b1;
    m_imr = 8'hFF; m_isr = 8'h00; m_ready = 1'b0; m_aeoi = 1'b0; m_base = 5'd0;
    idle(2);
    rd(1'b1, v, oe); chk("post_rst_imr", v, m_imr);
    begin
      logic im;
      inta(v, oe, im);
      chk("post_rst_vecoe", 8'(oe), 8'd0);
      chk("post_rst_intr", 8'(intr), 8'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
